// File: rtl/imm_builder.sv
// rtl/imm_builder.sv - chunked immediate assembler with sign/zero extension and overflow flag
module imm_builder #(
   parameter int IN_W       = 3,
   parameter int OUT_W      = 8,
   parameter int MAX_CHUNKS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             chunk_valid,
   output logic             chunk_ready,
   input  logic [IN_W-1:0]  chunk_data,
   input  logic             chunk_last,
   input  logic             sign_mode,
   input  logic             flush,
   output logic             imm_valid,
   input  logic             imm_ready,
   output logic [OUT_W-1:0] imm_out,
   output logic             overflow
);

   localparam int ACC_W = IN_W * MAX_CHUNKS;
   localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mode_q, mode_d;
   logic [OUT_W-1:0]   imm_q, imm_d;
   logic               ovf_q, ovf_d;

   logic [ACC_W-1:0]   acc_nx;
   logic [CNT_W-1:0]   cnt_nx;
   logic               mode_nx;
   logic [OUT_W-1:0]   ext_imm;
   logic               ext_ovf;
   logic               accept;

   assign chunk_ready = !reset && (state_q != S_HOLD);
   assign accept      = chunk_valid && chunk_ready && !flush;
   assign imm_valid   = (state_q == S_HOLD);
   assign imm_out     = imm_q;
   assign overflow    = ovf_q;

   // Candidate accumulator/count/mode if the presented chunk is taken; the first chunk restarts them
   always_comb begin
      acc_nx  = (acc_q << IN_W) | ACC_W'(chunk_data);
      cnt_nx  = cnt_q + CNT_W'(1);
      mode_nx = mode_q;
      if (state_q == S_IDLE) begin
         acc_nx  = ACC_W'(chunk_data);
         cnt_nx  = CNT_W'(1);
         mode_nx = sign_mode;
      end
   end

   // Extend or truncate the candidate to OUT_W and detect values that do not fit
   always_comb begin
      int                     b;
      logic                   s;
      logic [ACC_W+OUT_W-1:0] wide;
      b    = int'(cnt_nx) * IN_W;
      wide = {{OUT_W{1'b0}}, acc_nx};
      s    = 1'b0;
      for (int i = 0; i < ACC_W; i++) begin
         if (mode_nx && (i == b - 1)) s = acc_nx[i];
      end
      for (int i = 0; i < OUT_W; i++) begin
         ext_imm[i] = (i < b) ? wide[i] : s;
      end
      ext_ovf = 1'b0;
      for (int i = OUT_W; i < ACC_W; i++) begin
         if ((i < b) && (wide[i] != (mode_nx ? ext_imm[OUT_W-1] : 1'b0))) ext_ovf = 1'b1;
      end
   end

   // Next-state logic: flush wins, then per-state chunk acceptance and result handshake
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      imm_d   = imm_q;
      ovf_d   = ovf_q;
      if (flush) begin
         state_d = S_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_ACCUM: begin
               if (accept) begin
                  acc_d   = acc_nx;
                  cnt_d   = cnt_nx;
                  mode_d  = mode_nx;
                  state_d = S_ACCUM;
                  if (chunk_last || (cnt_nx == CNT_W'(MAX_CHUNKS))) begin
                     state_d = S_HOLD;
                     imm_d   = ext_imm;
                     ovf_d   = ext_ovf;
                  end
               end
            end
            S_HOLD: begin
               if (imm_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         imm_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         imm_q   <= imm_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_imm_builder.sv
// tb/tb_imm_builder.sv - randomized self-checking bench for imm_builder
module tb_imm_builder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       chunk_valid = 1'b0;
   logic       chunk_ready;
   logic [2:0] chunk_data = 3'd0;
   logic       chunk_last = 1'b0;
   logic       sign_mode = 1'b0;
   logic       flush = 1'b0;
   logic       imm_valid;
   logic       imm_ready = 1'b0;
   logic [7:0] imm_out;
   logic       overflow;

   int vectors = 0;
   int miscompares = 0;

   imm_builder #(.IN_W(3), .OUT_W(8), .MAX_CHUNKS(3)) dut (
      .clk(clk), .reset(reset),
      .chunk_valid(chunk_valid), .chunk_ready(chunk_ready),
      .chunk_data(chunk_data), .chunk_last(chunk_last),
      .sign_mode(sign_mode), .flush(flush),
      .imm_valid(imm_valid), .imm_ready(imm_ready),
      .imm_out(imm_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: integer concatenation, two's-complement interpretation, range test
   task automatic model(input int n, input logic [2:0] c0, input logic [2:0] c1,
                        input logic [2:0] c2, input bit mode,
                        output logic [7:0] imm, output bit ovf);
      logic [2:0] cs [3];
      longint v, sv, lo;
      int b;
      cs = '{c0, c1, c2};
      v = 0;
      for (int i = 0; i < n; i++) v = v * 8 + longint'(cs[i]);
      b  = 3 * n;
      sv = v;
      if (mode && v >= (longint'(1) << (b - 1))) sv = v - (longint'(1) << b);
      lo  = sv & 255;
      imm = lo[7:0];
      ovf = mode ? (sv < -128 || sv > 127) : (v > 255);
   endtask

   task automatic send(input logic [2:0] d, input bit last, input bit sm);
      chunk_valid = 1'b1;
      chunk_data  = d;
      chunk_last  = last;
      sign_mode   = sm;
      tick();
      chunk_valid = 1'b0;
      chunk_last  = 1'b0;
   endtask

   task automatic run_txn(input int n, input bit use_last, input bit mode,
                          input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                          input int bp);
      logic [2:0] cs [3];
      logic [7:0] e_imm;
      bit         e_ovf;
      cs = '{c0, c1, c2};
      model(n, c0, c1, c2, mode, e_imm, e_ovf);
      chk("rdy_idle", chunk_ready, 1);
      for (int i = 0; i < n; i++) begin
         // sign_mode is flipped after the first chunk; it must be ignored there
         send(cs[i], use_last && (i == n - 1), (i == 0) ? mode : !mode);
         if (i < n - 1) chk("valid_mid", imm_valid, 0);
      end
      chk("valid", imm_valid, 1);
      chk("imm", imm_out, e_imm);
      chk("ovf", overflow, e_ovf);
      for (int k = 0; k < bp; k++) begin
         chunk_valid = 1'b1;
         chunk_data  = 3'($urandom);
         chunk_last  = 1'b1;
         tick();
         chk("bp_valid", imm_valid, 1);
         chk("bp_imm", imm_out, e_imm);
         chk("bp_ovf", overflow, e_ovf);
         chk("bp_rdy", chunk_ready, 0);
      end
      chunk_valid = 1'b0;
      chunk_last  = 1'b0;
      imm_ready   = 1'b1;
      tick();
      imm_ready = 1'b0;
      chk("hs_valid", imm_valid, 0);
      chk("hs_rdy", chunk_ready, 1);
      chk("hs_imm_kept", imm_out, e_imm);
   endtask

   initial begin
      #1;
      chk("rst_valid", imm_valid, 0);
      chk("rst_imm", imm_out, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_rdy", chunk_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("rel_rdy", chunk_ready, 1);

      run_txn(1, 1, 1, 3'b101, 3'b000, 3'b000, 0);
      run_txn(1, 1, 0, 3'b101, 3'b000, 3'b000, 0);
      run_txn(2, 1, 1, 3'b011, 3'b110, 3'b000, 0);
      run_txn(3, 0, 1, 3'b111, 3'b111, 3'b000, 0);
      run_txn(3, 0, 0, 3'b111, 3'b111, 3'b000, 0);
      run_txn(1, 1, 1, 3'b101, 3'b000, 3'b000, 5);

      // flush during ACCUM, with a competing chunk in the flush cycle
      send(3'b011, 0, 1);
      chunk_valid = 1'b1; chunk_data = 3'b110; chunk_last = 1'b1; flush = 1'b1;
      tick();
      chunk_valid = 1'b0; chunk_last = 1'b0; flush = 1'b0;
      chk("fl_acc_valid", imm_valid, 0);
      tick();
      chk("fl_acc_valid2", imm_valid, 0);

      // flush during HOLD clears valid and overflow
      send(3'b111, 0, 0);
      send(3'b111, 0, 0);
      send(3'b000, 0, 0);
      chk("fl_hold_pre_valid", imm_valid, 1);
      chk("fl_hold_pre_ovf", overflow, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_hold_valid", imm_valid, 0);
      chk("fl_hold_ovf", overflow, 0);
      chk("fl_hold_rdy", chunk_ready, 1);
      run_txn(1, 1, 1, 3'b010, 3'b000, 3'b000, 0);

      // async reset mid-ACCUM
      send(3'b101, 0, 1);
      #2 reset = 1'b1;
      #1;
      chk("ra_valid", imm_valid, 0);
      chk("ra_imm", imm_out, 0);
      chk("ra_ovf", overflow, 0);
      chk("ra_rdy", chunk_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("ra_rel_rdy", chunk_ready, 1);
      tick();

      // async reset mid-HOLD
      send(3'b111, 0, 0);
      send(3'b111, 0, 0);
      send(3'b000, 0, 0);
      chk("rh_pre_valid", imm_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("rh_valid", imm_valid, 0);
      chk("rh_imm", imm_out, 0);
      chk("rh_ovf", overflow, 0);
      chk("rh_rdy", chunk_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("rh_rel_rdy", chunk_ready, 1);
      tick();

      for (int t = 0; t < 60; t++) begin
         bit use_last;
         int n;
         use_last = 1'($urandom);
         n = use_last ? 1 + int'($urandom % 3) : 3;
         run_txn(n, use_last, 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                 int'($urandom % 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
